// File: rtl/dmem_arbiter.sv
// Two-core data-memory arbiter: round-robin grant onto one single-port RAM,
// same-address load merging, and fixed two-cycle read return per core.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [15:0]       c1_AR,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  input  logic              c2_req,
  input  logic              c2_we,
  input  logic [15:0]       c2_AR,
  input  logic [DATA_W-1:0] c2_wdata,
  output logic              c2_ack,
  output logic              c2_rvalid,
  output logic [DATA_W-1:0] c2_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  logic [1:0]        ack_q, ack_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic [1:0]        vld_p0;
  logic [1:0]        vld_p1_q;
  logic [1:0]        vld_p2_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;

  logic elig1, elig2, same_addr, merge, gnt1, gnt2;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{c1_AR[15:ADDR_W], c2_AR[15:ADDR_W]};

  // last_q = 0: core 1 granted last; 1: core 2 granted last
  always_comb begin
    elig1     = c1_req & ~ack_q[0];
    elig2     = c2_req & ~ack_q[1];
    same_addr = (c1_AR[ADDR_W-1:0] == c2_AR[ADDR_W-1:0]);
    merge     = elig1 & elig2 & ~c1_we & ~c2_we & same_addr;
    gnt1      = elig1 & (~elig2 | merge |  last_q);
    gnt2      = elig2 & (~elig1 | merge | ~last_q);

    addr_d = addr_q;
    data_d = data_q;
    wren_d = 1'b0;
    last_d = last_q;
    ack_d  = {gnt2, gnt1};

    if (gnt1) begin
      addr_d = c1_AR[ADDR_W-1:0];
      data_d = c1_wdata;
      wren_d = c1_we;
    end else if (gnt2) begin
      addr_d = c2_AR[ADDR_W-1:0];
      data_d = c2_wdata;
      wren_d = c2_we;
    end

    // A merged read leaves the fairness pointer where it was
    if (gnt1 && !gnt2) begin
      last_d = 1'b0;
    end else if (gnt2 && !gnt1) begin
      last_d = 1'b1;
    end

    vld_p0 = {gnt2 & ~c2_we, gnt1 & ~c1_we};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q    <= 2'b00;
      last_q   <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      vld_p1_q <= 2'b00;
      vld_p2_q <= 2'b00;
      rvalid_q <= 2'b00;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      // grant stage: drive the RAM port and acknowledge
      ack_q    <= ack_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      vld_p1_q <= vld_p0;
      // RAM address capture stage
      vld_p2_q <= vld_p1_q;
      // return stage: mem_q is valid for the load granted two edges ago
      rvalid_q <= vld_p2_q;
      if (vld_p2_q[0]) begin
        rdata1_q <= mem_q;
      end
      if (vld_p2_q[1]) begin
        rdata2_q <= mem_q;
      end
    end
  end

  assign c1_ack      = ack_q[0];
  assign c2_ack      = ack_q[1];
  assign c1_rvalid   = rvalid_q[0];
  assign c2_rvalid   = rvalid_q[1];
  assign c1_rdata    = rdata1_q;
  assign c2_rdata    = rdata2_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of two-core transactions against a synchronous
// RAM model, plus reset-during-load and sustained-contention sequences.
module tb_dmem_arbiter;

  logic        clk;
  logic        rstn;
  logic        c1_req, c1_we, c2_req, c2_we;
  logic [15:0] c1_AR, c1_wdata, c2_AR, c2_wdata;
  logic        c1_ack, c1_rvalid, c2_ack, c2_rvalid;
  logic [15:0] c1_rdata, c2_rdata;
  logic [7:0]  mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .c1_req(c1_req), .c1_we(c1_we), .c1_AR(c1_AR), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .c2_req(c2_req), .c2_we(c2_we), .c2_AR(c2_AR), .c2_wdata(c2_wdata),
    .c2_ack(c2_ack), .c2_rvalid(c2_rvalid), .c2_rdata(c2_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with registered address, plus a bench-only preload port
  logic [15:0] ram [0:255];
  logic [7:0]  ram_a_q;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wren) ram[mem_address] <= mem_data;
    ram_a_q <= mem_address;
  end
  assign mem_q = ram[ram_a_q];

  int tests = 0;
  int fails = 0;
  int wren_cnt = 0;
  int wren_bad = 0;
  always @(negedge clk) begin
    if (rstn && mem_wren) begin
      wren_cnt++;
      if (!(c1_ack || c2_ack)) wren_bad++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  function automatic logic [15:0] expv(input logic [7:0] a);
    return {~a, a};
  endfunction

  typedef struct {
    logic        en1, we1;
    logic [15:0] a1, d1;
    logic        en2, we2;
    logic [15:0] a2, d2;
    int          ord;   // 1: c1 first/only, 2: c2 first/only, 3: same cycle
    logic [15:0] r1, r2;
  } vec_t;

  function automatic vec_t mk(input logic en1, we1, input logic [15:0] a1, d1,
                              input logic en2, we2, input logic [15:0] a2, d2,
                              input int ord, input logic [15:0] r1, r2);
    vec_t v;
    v.en1 = en1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.en2 = en2; v.we2 = we2; v.a2 = a2; v.d2 = d2;
    v.ord = ord; v.r1 = r1; v.r2 = r2;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int t1 = -1, t2 = -1, rv1 = -1, rv2 = -1;
    int na1 = 0, na2 = 0, nrv1 = 0, nrv2 = 0, ord;
    logic [15:0] g1 = '0, g2 = '0;
    string nm;
    @(negedge clk);
    c1_req = v.en1; c1_we = v.we1; c1_AR = v.a1; c1_wdata = v.d1;
    c2_req = v.en2; c2_we = v.we2; c2_AR = v.a2; c2_wdata = v.d2;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c1_ack) begin na1++; if (t1 < 0) t1 = c; c1_req = 1'b0; end
      if (c2_ack) begin na2++; if (t2 < 0) t2 = c; c2_req = 1'b0; end
      if (c1_rvalid) begin nrv1++; rv1 = c; g1 = c1_rdata; end
      if (c2_rvalid) begin nrv2++; rv2 = c; g2 = c2_rdata; end
    end
    c1_req = 1'b0; c2_req = 1'b0;
    if (t1 >= 0 && t2 >= 0) ord = (t1 < t2) ? 1 : ((t2 < t1) ? 2 : 3);
    else ord = (t1 >= 0) ? 1 : ((t2 >= 0) ? 2 : 0);
    nm = $sformatf("v%0d", idx);
    chk({nm, " grant order"}, ord, v.ord);
    chk({nm, " c1 ack count"}, na1, v.en1);
    chk({nm, " c2 ack count"}, na2, v.en2);
    if (v.en1 && v.en2 && v.ord != 3)
      chk({nm, " second grant gap"}, (t1 > t2) ? t1 - t2 : t2 - t1, 1);
    if (v.en1 && !v.we1)
      chk({nm, " c1 rvalid cnt/cycle/data"}, {nrv1[7:0], rv1[7:0], g1},
          {8'd1, 8'(t1 + 2), v.r1});
    else
      chk({nm, " c1 rvalid count"}, nrv1, 0);
    if (v.en2 && !v.we2)
      chk({nm, " c2 rvalid cnt/cycle/data"}, {nrv2[7:0], rv2[7:0], g2},
          {8'd1, 8'(t2 + 2), v.r2});
    else
      chk({nm, " c2 rvalid count"}, nrv2, 0);
  endtask

  vec_t vt[11];
  int   rv_seen;
  int   n1, n2, prev, cur, alt_bad;
  logic [15:0] fa1, fa2;
  int   q1_c[$], q2_c[$];
  logic [15:0] q1_d[$], q2_d[$];

  initial begin
    rstn = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    c1_req = 0; c1_we = 0; c1_AR = '0; c1_wdata = '0;
    c2_req = 0; c2_we = 0; c2_AR = '0; c2_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {c1_ack, c2_ack, c1_rvalid, c2_rvalid, c1_rdata, c2_rdata,
                          mem_address, mem_data, mem_wren}, '0);

    poke(8'h05, 16'hBEEF); poke(8'h10, 16'h0000); poke(8'h20, 16'h0000);
    poke(8'h30, 16'h1111); poke(8'h31, 16'h2222); poke(8'h40, 16'hABCD);
    for (int i = 0; i < 16; i++) begin
      poke(8'h80 + 8'(i), expv(8'h80 + 8'(i)));
      poke(8'hC0 + 8'(i), expv(8'hC0 + 8'(i)));
    end
    @(negedge clk) rstn = 1'b1;

    vt[0]  = mk(1,0,16'h0005,16'h0000, 0,0,16'h0000,16'h0000, 1, 16'hBEEF, 16'h0000);
    vt[1]  = mk(0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000, 2, 16'h0000, 16'h1111);
    vt[2]  = mk(1,1,16'h0010,16'hAAAA, 1,1,16'h0010,16'h5555, 1, 16'h0000, 16'h0000);
    vt[3]  = mk(1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1, 16'h5555, 16'h0000);
    vt[4]  = mk(0,0,16'h0000,16'h0000, 1,0,16'h0031,16'h0000, 2, 16'h0000, 16'h2222);
    vt[5]  = mk(1,1,16'h0020,16'h00FF, 1,0,16'h0020,16'h0000, 1, 16'h0000, 16'h00FF);
    vt[6]  = mk(0,0,16'h0000,16'h0000, 1,1,16'h0105,16'h1234, 2, 16'h0000, 16'h0000);
    vt[7]  = mk(1,0,16'h0105,16'h0000, 1,0,16'h0005,16'h0000, 3, 16'h1234, 16'h1234);
    vt[8]  = mk(1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 1, 16'h1111, 16'hABCD);
    vt[9]  = mk(1,0,16'h0040,16'h0000, 1,1,16'h0040,16'h7777, 1, 16'hABCD, 16'h0000);
    vt[10] = mk(0,0,16'h0000,16'h0000, 1,0,16'h0040,16'h0000, 2, 16'h0000, 16'h7777);
    for (int i = 0; i < 11; i++) run_vec(vt[i], i);
    chk("store wren cycles", wren_cnt, 5);

    // Reset while a load is in flight: outputs clear at once, load never returns
    @(negedge clk);
    c1_req = 1; c1_we = 0; c1_AR = 16'h0005; c1_wdata = 16'hFFFF;
    @(posedge clk); #1;
    chk("mid-reset load ack", c1_ack, 1'b1);
    c1_req = 0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("async reset outputs", {c1_ack, c2_ack, c1_rvalid, c2_rvalid, c1_rdata, c2_rdata,
                                mem_address, mem_data, mem_wren}, '0);
    rv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) rstn = 1'b1;
      if (c1_rvalid || c2_rvalid) rv_seen++;
    end
    chk("no rvalid after reset", rv_seen, 0);
    run_vec(mk(1,0,16'h0030,16'h0000, 1,0,16'h0031,16'h0000, 1, 16'h1111, 16'h2222), 11);

    // Sustained contention with distinct addresses
    n1 = 0; n2 = 0; prev = 0; alt_bad = 0;
    fa1 = 16'h0080; fa2 = 16'h00C0;
    @(negedge clk);
    c1_req = 1; c1_we = 0; c1_AR = fa1;
    c2_req = 1; c2_we = 0; c2_AR = fa2;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (c < 20) begin
        cur = (c1_ack && c2_ack) ? 3 : (c1_ack ? 1 : (c2_ack ? 2 : 0));
        if (cur == 0 || cur == 3 || cur == prev) alt_bad++;
        prev = cur;
        if (c1_ack) begin
          n1++; q1_c.push_back(c + 2); q1_d.push_back(expv(fa1[7:0]));
          fa1++; c1_AR = fa1;
        end
        if (c2_ack) begin
          n2++; q2_c.push_back(c + 2); q2_d.push_back(expv(fa2[7:0]));
          fa2++; c2_AR = fa2;
        end
        if (c == 19) begin c1_req = 0; c2_req = 0; end
      end
      if (c1_rvalid) begin
        if (q1_c.size() == 0) chk("fair c1 unexpected rvalid", c, -1);
        else chk($sformatf("fair c1 return cyc%0d", c), {q1_c.pop_front(), q1_d.pop_front()},
                 {c, c1_rdata});
      end
      if (c2_rvalid) begin
        if (q2_c.size() == 0) chk("fair c2 unexpected rvalid", c, -1);
        else chk($sformatf("fair c2 return cyc%0d", c), {q2_c.pop_front(), q2_d.pop_front()},
                 {c, c2_rdata});
      end
    end
    chk("fair c1 grants", n1, 10);
    chk("fair c2 grants", n2, 10);
    chk("fair alternation breaks", alt_bad, 0);
    chk("fair loads outstanding", q1_c.size() + q2_c.size(), 0);
    chk("wren without ack", wren_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-core data-memory arbiter sitting directly upstream of the single-port data RAM and the per-core read-return path. It accepts load/store requests from core 1 and core 2, serialises them onto one memory port with round-robin fairness, merges simultaneous same-address reads into one access, and returns read data to the requesting core with a fixed latency. It replaces ad-hoc address muxing with an explicit request/acknowledge handshake.

## Interface

- ADDR_W, 8, memory word-address width; low ADDR_W bits of each 16-bit address are used, upper bits ignored
- DATA_W, 16, data width
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- c1_req  in  1  core 1 request; held high until c1_ack seen
- c1_we  in  1  core 1 write enable (1 = store, 0 = load); stable while c1_req high
- c1_AR  in  16  core 1 address; stable while c1_req high
- c1_wdata  in  DATA_W  core 1 store data; stable while c1_req high
- c1_ack  out  1  one-cycle pulse: core 1 request accepted
- c1_rvalid  out  1  one-cycle pulse: c1_rdata holds load result
- c1_rdata  out  DATA_W  core 1 load result; holds until next core 1 load returns
- c2_req, c2_we, c2_AR, c2_wdata, c2_ack, c2_rvalid, c2_rdata: identical for core 2
- mem_address  out  ADDR_W  registered RAM address
- mem_data  out  DATA_W  registered RAM write data
- mem_wren  out  1  registered RAM write enable
- mem_q  in  DATA_W  RAM read data; valid the cycle after the RAM clocks mem_address (RAM registers address internally)

## Operation

- Eligibility per edge: core k eligible iff ck_req=1 and ck_ack=0 (request is consumed in the cycle its ack is high; core must drop or change req during that cycle).
- Round-robin pointer `last` (1 bit, core last granted). Reset value: core 2, so core 1 wins first conflict.
- Grant rules at each edge:
  - neither eligible: mem_wren<=0, mem_address/mem_data hold, no ack.
  - one eligible: grant it.
  - both eligible, both loads, low ADDR_W address bits equal: merge — one RAM read, both acks pulse, both rvalid pulse together with same data; last unchanged.
  - both eligible otherwise (incl. both stores to same address): grant core != last; loser stays eligible and is granted next edge (stores then land in grant order, last write wins).
- On grant: mem_address<=ck_AR[ADDR_W-1:0], mem_data<=ck_wdata, mem_wren<=ck_we, ck_ack<=1, last<=k (non-merge).
- Load return tracked by a 2-stage tag pipeline (valid bit per core); stores produce no rvalid.
- Reset (any time, asynchronous): all outputs 0 (ack, rvalid, rdata, mem_address, mem_data, mem_wren), pipeline tags cleared; in-flight loads are dropped, never returned.

## Timing

- Grant at edge E: ack high during cycle E..E+1; mem_* valid from E.
- RAM captures address at E+1; mem_q valid after E+1; arbiter registers mem_q into ck_rdata at E+2; ck_rvalid high exactly cycle E+2..E+3.
- Store at edge E is written by RAM at edge E+1; a load granted at E+1 or later to the same address returns the new value.
- Throughput: one access per cycle total; a single core issuing back-to-back gets at most one grant every 2 cycles (req ignored during its ack cycle).
- Continuous contention from both cores: grants alternate 1,2,1,2 every cycle.
- mem_wren is high for exactly one cycle per store grant; never high without a corresponding ack.

## Test plan

- Reset: assert rstn=0 mid-load (req granted, rvalid pending) -> all outputs 0 immediately, no rvalid after release; first conflict after reset grants core 1.
- Single load: RAM[0x05]=0xBEEF, c1 load 0x0005 granted at edge E -> c1_ack cycle E, c1_rvalid=1 with c1_rdata=0xBEEF at cycle E+2 only; c2 outputs untouched.
- Merge: c1 and c2 load 0x0105 and 0x0005 same cycle (low 8 bits equal), RAM[0x05]=0x1234 -> one mem access, both acks same cycle, both rvalid same cycle, both rdata=0x1234.
- Store conflict: c1 stores 0xAAAA, c2 stores 0x5555 to 0x10 together after reset -> c1 granted first, c2 next edge, subsequent load of 0x10 returns 0x5555.
- Store-then-load: c1 stores 0x00FF to 0x20 at edge E, c2 loads 0x20 granted E+1 -> c2_rdata=0x00FF.
- Fairness: both cores hold continuous distinct-address loads for 20 cycles -> acks alternate, 10 grants each (±1), every load returns correct data at grant+2.
